// File: rtl/uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : uart_pkg                                                     |
// | Desc    : Shared UART byte width and transmit-arbiter state encoding.  |
// | Rev     : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
package uart_pkg;

   localparam int UART_DW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_hold.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : uart_tx_hold                                                 |
// | Desc    : One-entry valid/ready holding register for a UART producer.  |
// | Rev     : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module uart_tx_hold
   import uart_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic [UART_DW-1:0] i_load_data,
   output logic               o_load_rdy,
   output logic [UART_DW-1:0] o_out_data,
   output logic               o_out_vld,
   input  logic               i_out_rdy
);

   logic               r_vld;
   logic [UART_DW-1:0] r_data;

   // Accepts a new byte when empty or when the current one leaves this cycle.
   assign o_load_rdy = !r_vld || i_out_rdy;
   assign o_out_vld  = r_vld;
   assign o_out_data = r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= 1'b0;
         r_data <= '0;
      end else if (i_load) begin
         r_vld  <= 1'b1;
         r_data <= i_load_data;
      end else if (i_out_rdy) begin
         r_vld  <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : uart_tx_arb                                                  |
// | Desc    : Round-robin message arbiter sharing uart_tx between 2 ports. |
// | Rev     : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int MAX_BURST = 16,
   parameter int TIMEOUT   = 1024
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [UART_DW-1:0] req0_data_i,
   input  logic               req0_vld_i,
   input  logic               req0_last_i,
   output logic               req0_rdy_o,
   input  logic [UART_DW-1:0] req1_data_i,
   input  logic               req1_vld_i,
   input  logic               req1_last_i,
   output logic               req1_rdy_o,
   output logic [UART_DW-1:0] uart_tx_data_o,
   output logic               uart_tx_data_vld_o,
   input  logic               uart_tx_data_rdy_i,
   output logic [1:0]         grant_o,
   output logic               timeout_o
);

   localparam int c_burst_w = $clog2(MAX_BURST + 1);
   localparam int c_idle_w  = $clog2(TIMEOUT);
   localparam logic [c_burst_w-1:0] c_burst_max = c_burst_w'(MAX_BURST);
   localparam logic [c_idle_w-1:0]  c_idle_max  = c_idle_w'(TIMEOUT - 1);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic                r_last_served;
   logic [c_burst_w-1:0] r_burst_cnt;
   logic [c_burst_w-1:0] w_burst_inc;
   logic [c_idle_w-1:0]  r_idle_cnt;
   logic                w_hold_rdy;
   logic                w_xfer;
   logic                w_sel_last;
   logic [UART_DW-1:0]  w_sel_data;
   logic                w_release;

   assign grant_o     = {r_state == GNT1, r_state == GNT0};
   assign w_burst_inc = r_burst_cnt + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      req0_rdy_o  = 1'b0;
      req1_rdy_o  = 1'b0;
      w_xfer      = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_data  = req0_data_i;
      w_release   = 1'b0;
      timeout_o   = 1'b0;
      case (r_state)
         IDLE: begin
            // On a tie, the port that was not served last wins.
            if (req0_vld_i && (!req1_vld_i || r_last_served))
               w_state_nxt = GNT0;
            else if (req1_vld_i)
               w_state_nxt = GNT1;
         end
         GNT0: begin
            req0_rdy_o = w_hold_rdy;
            w_xfer     = req0_vld_i && w_hold_rdy;
            w_sel_data = req0_data_i;
            w_sel_last = req0_last_i;
         end
         GNT1: begin
            req1_rdy_o = w_hold_rdy;
            w_xfer     = req1_vld_i && w_hold_rdy;
            w_sel_data = req1_data_i;
            w_sel_last = req1_last_i;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (r_state != IDLE) begin
         timeout_o = !w_xfer && (r_idle_cnt == c_idle_max);
         w_release = (w_xfer && (w_sel_last || (w_burst_inc == c_burst_max))) || timeout_o;
         if (w_release)
            w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Counters only run while granted and are cleared on every release.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_burst_cnt   <= '0;
         r_idle_cnt    <= '0;
         r_last_served <= 1'b1;
      end else if (w_release) begin
         r_burst_cnt   <= '0;
         r_idle_cnt    <= '0;
         r_last_served <= (r_state == GNT1);
      end else if (r_state != IDLE) begin
         if (w_xfer) begin
            r_burst_cnt <= w_burst_inc;
            r_idle_cnt  <= '0;
         end else begin
            r_idle_cnt  <= r_idle_cnt + 1'b1;
         end
      end
   end

   uart_tx_hold u_hold (
      .clk         (clk_i),
      .rst_n       (rst_n_i),
      .i_load      (w_xfer),
      .i_load_data (w_sel_data),
      .o_load_rdy  (w_hold_rdy),
      .o_out_data  (uart_tx_data_o),
      .o_out_vld   (uart_tx_data_vld_o),
      .i_out_rdy   (uart_tx_data_rdy_i)
   );

endmodule
`default_nettype wire

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares the single `uart_tx` byte channel between two requesters: port 0 (the UART loader's dump/response stream) and port 1 (the CPU console stream). It sits between those producers and `uart_tx`. It holds a grant for a whole message (`last`), bounded by a burst limit and an idle timeout so neither side can starve the other. Output is a one-byte registered holding stage driving `uart_tx`'s valid/ready handshake.

## Interface
- `MAX_BURST`, 16: max bytes per grant before forced release (≥1).
- `TIMEOUT`, 1024: cycles a granted requester may stall (`vld` low, no `last` seen) before grant is revoked (≥2).
- `clk_i` in 1: system clock (`sys_clk`).
- `rst_n_i` in 1: asynchronous, active-low reset.
- `req0_data_i` in 8: port 0 byte.
- `req0_vld_i` in 1: port 0 byte valid.
- `req0_last_i` in 1: port 0 byte is final of message (qualified by transfer).
- `req0_rdy_o` out 1: port 0 byte accepted this cycle when `vld`&`rdy`.
- `req1_data_i`, `req1_vld_i`, `req1_last_i`, `req1_rdy_o`: same for port 1.
- `uart_tx_data_o` out 8: byte to `uart_tx`.
- `uart_tx_data_vld_o` out 1: holding register full.
- `uart_tx_data_rdy_i` in 1: `uart_tx` accepts byte when `vld`&`rdy`.
- `grant_o` out 2: one-hot current grant, `00` in IDLE.
- `timeout_o` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE, GNT0, GNT1.
- IDLE:
  - only one `reqN_vld_i` high → GNTN;
  - both high → grant the port that is not `last_served`;
  - neither → stay.
- GNTN:
  - `reqN_rdy_o = !uart_tx_data_vld_o || uart_tx_data_rdy_i`; the other port's `rdy` is 0.
  - A port transfer loads the holding register and increments `burst_cnt`.
- Release GNTN → IDLE at the end of the cycle in which any of these occurs:
  - transfer with `last=1`;
  - transfer that makes `burst_cnt == MAX_BURST`;
  - `idle_cnt` reaches `TIMEOUT-1` with no transfer (also pulses `timeout_o`).
- On release: `last_served ← N`; `burst_cnt`, `idle_cnt` ← 0.
- `idle_cnt` counts cycles in GNTN without a port transfer and clears on each transfer. `last` and the burst limit in the same transfer cause a single release.
- The holding register drains independently of the state. A byte loaded on the releasing cycle is still sent.
- Ports are never granted while in IDLE, so the minimum gap between grants is one cycle.

## Timing
- Reset values:
  - all outputs 0;
  - `uart_tx_data_o` = 8'h00;
  - state IDLE;
  - `last_served` = 1, so port 0 wins the first tie;
  - counters 0.
- Latency:
  - request seen in IDLE at cycle n → `grant_o` and `rdy` high at n+1;
  - byte transferred at n+1 → `uart_tx_data_vld_o` at n+2.
- Throughput: one byte per cycle when `uart_tx_data_rdy_i` stays high (load and drain in the same cycle).
- `uart_tx_data_o` is stable while `uart_tx_data_vld_o`=1 and `uart_tx_data_rdy_i`=0.
- Requesters may drop `vld` at any time. A dropped byte is simply not taken.
- Reset mid-operation discards the held byte and any grant immediately, asynchronously.
- `burst_cnt` width is `$clog2(MAX_BURST+1)`; `idle_cnt` width is `$clog2(TIMEOUT)`. Neither counter wraps: each is cleared on release.

## Structure
- Shared package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t`;
  - byte-width constant `UART_DW = 8`.
- One natural sub-module, `uart_tx_hold`: a one-entry valid/ready holding register (load/drain logic), reusable for other UART producers.
- Everything else (FSM, counters, round-robin pointer) stays in `uart_tx_arb`.

## Test plan
- **Single requester:** port 1 sends 0x48,0x49 (last on 0x49) with `uart_tx_data_rdy_i`=1 → `grant_o`=10 one cycle after `vld`; bytes appear on `uart_tx_data_o` in order, one per cycle; IDLE after 0x49.
- **Tie after reset:** both `vld` in the same cycle → port 0 granted first; after its `last`, port 1 granted with exactly one IDLE cycle between grants.
- **Burst limit:** `MAX_BURST`=4, port 0 streams 10 bytes with no `last`, port 1 waiting → port 0 sends 4 bytes, port 1's message follows, then port 0 resumes.
- **Backpressure:** hold `uart_tx_data_rdy_i`=0 for 50 cycles mid-message → `uart_tx_data_o` constant, `req_rdy` low, no byte lost or duplicated, and `timeout_o` does not fire.
- **Timeout:** `TIMEOUT`=8, port 1 granted, drops `vld` without `last` → `timeout_o` pulses at the 8th idle cycle; pending port 0 granted next.
- **Reset mid-message:** assert `rst_n_i` low with a byte held → `uart_tx_data_vld_o`, `grant_o` and all `rdy` go 0 immediately; after release, the first tie goes to port 0.
